// File: rtl/link_bringup_ctrl.sv
// -----------------------------------------------------------------------------
// link_bringup_ctrl
// Brings a 10G-style link up in a fixed order:
//   1. wait for the transceiver TX/RX resets to complete,
//   2. wait for PCS block lock without high BER,
//   3. require the good lock to persist for STABLE_CYCLES,
//   4. release the MAC reset, write one MAC config register over Wishbone,
//      read it back and check it,
//   5. report link up and watch the PCS status.
// Any failure parks the FSM in FAULT for BACKOFF cycles, then it retries.
// Dropping enable returns to IDLE from any state.
//
// Ports
//   clk_156, async_reset_n        : clock, asynchronous active-low reset
//   enable                        : start / keep the link
//   reset_tx_done, reset_rx_done  : transceiver resets complete
//   blk_lock, hi_ber, rxlf        : PCS status (synchronous to clk_156)
//   wb_*                          : Wishbone master towards the MAC
//   mac_reset_n                   : MAC reset, released only while configuring / up
//   clear_ber_cnt, clear_errblk   : one-cycle pulse on the first CFG_WR cycle
//   link_up, fault                : status
//   retry_cnt                     : saturating count of FAULT entries
//   state_o                       : current FSM state
// -----------------------------------------------------------------------------
module link_bringup_ctrl #(
  parameter logic [15:0] LOCK_TIMEOUT  = 16'd50000,
  parameter logic [15:0] STABLE_CYCLES = 16'd1024,
  parameter logic [15:0] WB_TIMEOUT    = 16'd64,
  parameter logic [15:0] BACKOFF       = 16'd4096,
  parameter logic [7:0]  CFG_ADDR      = 8'h00,
  parameter logic [31:0] CFG_DATA      = 32'h0000_0001
) (
  input  logic        clk_156,
  input  logic        async_reset_n,
  input  logic        enable,
  input  logic        reset_tx_done,
  input  logic        reset_rx_done,
  input  logic        blk_lock,
  input  logic        hi_ber,
  input  logic        rxlf,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i,
  output logic        mac_reset_n,
  output logic        clear_ber_cnt,
  output logic        clear_errblk,
  output logic        link_up,
  output logic        fault,
  output logic [7:0]  retry_cnt,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_RST  = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_CFG_WR    = 3'd4,
    S_CFG_RD    = 3'd5,
    S_LINK_UP   = 3'd6,
    S_FAULT     = 3'd7
  } state_e;

  // Terminal counts. The 16-bit subtraction wraps 0 to 16'hFFFF, so a
  // parameter of 0 gives a full 65536-cycle interval.
  localparam logic [15:0] LOCK_LAST   = LOCK_TIMEOUT - 16'd1;
  localparam logic [15:0] STABLE_LAST = STABLE_CYCLES - 16'd1;
  localparam logic [15:0] WB_LAST     = WB_TIMEOUT - 16'd1;
  localparam logic [15:0] BACKOFF_LAST = BACKOFF - 16'd1;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;

  logic        wb_cyc_q, wb_stb_q, wb_we_q;
  logic [7:0]  wb_adr_q;
  logic [31:0] wb_dat_q;
  logic        mac_reset_n_q, clear_q, link_up_q, fault_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (enable) state_d = S_WAIT_RST;
      S_WAIT_RST:  if (reset_tx_done && reset_rx_done) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (blk_lock && !hi_ber)      state_d = S_STABLE;
        else if (cnt_q == LOCK_LAST)  state_d = S_FAULT;
      end
      S_STABLE: begin
        if (!blk_lock || hi_ber)        state_d = S_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)  state_d = S_CFG_WR;
      end
      S_CFG_WR: begin
        if (wb_ack_i)               state_d = S_CFG_RD;
        else if (cnt_q == WB_LAST)  state_d = S_FAULT;
      end
      S_CFG_RD: begin
        // The read strobe only goes out from the second CFG_RD cycle, so an
        // ack seen while the strobe is low cannot belong to the read.
        if (wb_stb_q && wb_ack_i)
          state_d = (wb_dat_i == CFG_DATA) ? S_LINK_UP : S_FAULT;
        else if (cnt_q == WB_LAST)
          state_d = S_FAULT;
      end
      S_LINK_UP:   if (!blk_lock || hi_ber || rxlf) state_d = S_FAULT;
      S_FAULT:     if (cnt_q == BACKOFF_LAST) state_d = S_WAIT_RST;
      default:     state_d = S_IDLE;
    endcase
    // Dropping enable overrides every other transition.
    if (state_q != S_IDLE && !enable) state_d = S_IDLE;
  end

  always_comb begin
    cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    retry_d = retry_q;
    if (state_d == S_FAULT && state_q != S_FAULT && retry_q != 8'hFF)
      retry_d = retry_q + 8'd1;
  end

  // State and registered outputs. Outputs are decoded from the next state so
  // they change in the same cycle as state_o.
  always_ff @(posedge clk_156 or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 16'd0;
      retry_q       <= 8'd0;
      wb_cyc_q      <= 1'b0;
      wb_stb_q      <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_adr_q      <= 8'd0;
      wb_dat_q      <= 32'd0;
      mac_reset_n_q <= 1'b0;
      clear_q       <= 1'b0;
      link_up_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      mac_reset_n_q <= (state_d == S_CFG_WR) || (state_d == S_CFG_RD) ||
                       (state_d == S_LINK_UP);
      clear_q       <= (state_d == S_CFG_WR) && (state_q != S_CFG_WR);
      link_up_q     <= (state_d == S_LINK_UP);
      fault_q       <= (state_d == S_FAULT);

      wb_cyc_q <= 1'b0;
      wb_stb_q <= 1'b0;
      wb_we_q  <= 1'b0;
      wb_adr_q <= 8'd0;
      wb_dat_q <= 32'd0;
      if (state_d == S_CFG_WR) begin
        wb_cyc_q <= 1'b1;
        wb_stb_q <= 1'b1;
        wb_we_q  <= 1'b1;
        wb_adr_q <= CFG_ADDR;
        wb_dat_q <= CFG_DATA;
      end else if (state_d == S_CFG_RD && state_q == S_CFG_RD) begin
        // First CFG_RD cycle keeps the bus idle to separate the two transfers.
        wb_cyc_q <= 1'b1;
        wb_stb_q <= 1'b1;
        wb_adr_q <= CFG_ADDR;
      end
    end
  end

  assign state_o       = state_q;
  assign retry_cnt     = retry_q;
  assign wb_cyc_o      = wb_cyc_q;
  assign wb_stb_o      = wb_stb_q;
  assign wb_we_o       = wb_we_q;
  assign wb_adr_o      = wb_adr_q;
  assign wb_dat_o      = wb_dat_q;
  assign mac_reset_n   = mac_reset_n_q;
  assign clear_ber_cnt = clear_q;
  assign clear_errblk  = clear_q;
  assign link_up       = link_up_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_link_bringup_ctrl.sv
// -----------------------------------------------------------------------------
// tb_link_bringup_ctrl
// Directed bring-up scenarios for link_bringup_ctrl with shortened intervals.
// Inputs change and outputs are sampled on the falling edge of clk_156.
// -----------------------------------------------------------------------------
module tb_link_bringup_ctrl;

  localparam logic [15:0] LT   = 16'd10;
  localparam logic [15:0] SC   = 16'd20;
  localparam logic [15:0] WT   = 16'd8;
  localparam logic [15:0] BO   = 16'd6;
  localparam logic [7:0]  ADDR = 8'h5A;
  localparam logic [31:0] DATA = 32'hCAFE_0001;

  logic        clk_156 = 1'b0;
  logic        async_reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        reset_tx_done = 1'b0;
  logic        reset_rx_done = 1'b0;
  logic        blk_lock = 1'b0;
  logic        hi_ber = 1'b0;
  logic        rxlf = 1'b0;
  logic        wb_ack_i = 1'b0;
  logic [31:0] wb_dat_i = 32'd0;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        mac_reset_n, clear_ber_cnt, clear_errblk, link_up, fault;
  logic [7:0]  retry_cnt;
  logic [2:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_156 = ~clk_156;

  link_bringup_ctrl #(
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .WB_TIMEOUT   (WT),
    .BACKOFF      (BO),
    .CFG_ADDR     (ADDR),
    .CFG_DATA     (DATA)
  ) dut (
    .clk_156      (clk_156),
    .async_reset_n(async_reset_n),
    .enable       (enable),
    .reset_tx_done(reset_tx_done),
    .reset_rx_done(reset_rx_done),
    .blk_lock     (blk_lock),
    .hi_ber       (hi_ber),
    .rxlf         (rxlf),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_we_o      (wb_we_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_ack_i     (wb_ack_i),
    .wb_dat_i     (wb_dat_i),
    .mac_reset_n  (mac_reset_n),
    .clear_ber_cnt(clear_ber_cnt),
    .clear_errblk (clear_errblk),
    .link_up      (link_up),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .state_o      (state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk_156);
  endtask

  // State plus the four status outputs in one go.
  task automatic check_status(input string tag, input logic [2:0] st, input logic mrn,
                              input logic lu, input logic flt);
    check({tag, ".state"},       {29'd0, state_o},     {29'd0, st});
    check({tag, ".mac_reset_n"}, {31'd0, mac_reset_n}, {31'd0, mrn});
    check({tag, ".link_up"},     {31'd0, link_up},     {31'd0, lu});
    check({tag, ".fault"},       {31'd0, fault},       {31'd0, flt});
  endtask

  task automatic check_bus(input string tag, input logic cyc, input logic stb,
                           input logic we, input logic [7:0] adr, input logic [31:0] dat);
    check({tag, ".cyc"}, {31'd0, wb_cyc_o}, {31'd0, cyc});
    check({tag, ".stb"}, {31'd0, wb_stb_o}, {31'd0, stb});
    check({tag, ".we"},  {31'd0, wb_we_o},  {31'd0, we});
    check({tag, ".adr"}, {24'd0, wb_adr_o}, {24'd0, adr});
    check({tag, ".dat"}, wb_dat_o, dat);
  endtask

  // Bounded wait for fault to rise; an expired budget is a failed comparison.
  task automatic wait_fault(input int limit);
    int c = 0;
    while (fault !== 1'b1 && c < limit) begin
      tick();
      c++;
    end
    check("fault_within_budget", {31'd0, fault}, 32'd1);
  endtask

  initial begin
    int exp_retry;

    // ---- reset state
    #1;
    check_status("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    check_bus("reset", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    check("reset.retry", {24'd0, retry_cnt}, 32'd0);
    check("reset.clear", {30'd0, clear_ber_cnt, clear_errblk}, 32'd0);
    tick();
    async_reset_n = 1'b1;

    // ---- clean bring-up
    enable = 1'b1; reset_tx_done = 1'b1; reset_rx_done = 1'b1; blk_lock = 1'b1;
    tick(); check("up.wait_rst", {29'd0, state_o}, 32'd1);
    tick(); check("up.wait_lock", {29'd0, state_o}, 32'd2);
    tick(); check("up.stable", {29'd0, state_o}, 32'd3);
    repeat (SC - 1) tick();
    check_status("up.stable_last", 3'd3, 1'b0, 1'b0, 1'b0);
    tick();
    check_status("up.cfg_wr", 3'd4, 1'b1, 1'b0, 1'b0);
    check("up.clear_ber", {31'd0, clear_ber_cnt}, 32'd1);
    check("up.clear_errblk", {31'd0, clear_errblk}, 32'd1);
    check_bus("up.wr", 1'b1, 1'b1, 1'b1, ADDR, DATA);
    tick();
    check("up.clear_once", {30'd0, clear_ber_cnt, clear_errblk}, 32'd0);
    check_bus("up.wr_hold", 1'b1, 1'b1, 1'b1, ADDR, DATA);
    tick();
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    check("up.cfg_rd", {29'd0, state_o}, 32'd5);
    check_bus("up.rd_gap", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    check_bus("up.rd", 1'b1, 1'b1, 1'b0, ADDR, 32'h0);
    wb_ack_i = 1'b1; wb_dat_i = DATA;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    check_status("up.link_up", 3'd6, 1'b1, 1'b1, 1'b0);
    check_bus("up.idle_bus", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    check("up.retry", {24'd0, retry_cnt}, 32'd0);

    // ---- remote fault drops the link
    rxlf = 1'b1;
    tick();
    rxlf = 1'b0;
    check_status("rxlf.fault", 3'd7, 1'b0, 1'b0, 1'b1);
    check("rxlf.retry", {24'd0, retry_cnt}, 32'd1);
    repeat (BO - 1) tick();
    check("rxlf.backoff_last", {29'd0, state_o}, 32'd7);
    tick();
    check("rxlf.retry_to_wait_rst", {29'd0, state_o}, 32'd1);

    // ---- lock never achieved
    blk_lock = 1'b0;
    tick(); check("nolock.wait_lock", {29'd0, state_o}, 32'd2);
    repeat (LT - 1) tick();
    check("nolock.last_cycle", {29'd0, state_o}, 32'd2);
    tick();
    check_status("nolock.fault", 3'd7, 1'b0, 1'b0, 1'b1);
    check("nolock.retry", {24'd0, retry_cnt}, 32'd2);

    // ---- lock with high BER, then lock glitch in STABLE
    repeat (BO) tick();
    check("glitch.wait_rst", {29'd0, state_o}, 32'd1);
    blk_lock = 1'b1; hi_ber = 1'b1;
    tick(); tick();
    check("glitch.hi_ber_holds", {29'd0, state_o}, 32'd2);
    hi_ber = 1'b0;
    tick(); check("glitch.stable", {29'd0, state_o}, 32'd3);
    repeat (10) tick();
    blk_lock = 1'b0;
    tick(); check("glitch.back_to_lock", {29'd0, state_o}, 32'd2);
    blk_lock = 1'b1;
    tick(); check("glitch.stable_again", {29'd0, state_o}, 32'd3);
    repeat (SC - 1) tick();
    check("glitch.full_count", {29'd0, state_o}, 32'd3);
    tick();
    check("glitch.cfg_wr", {29'd0, state_o}, 32'd4);

    // ---- write never acked
    repeat (WT - 1) tick();
    check_bus("wbto.last", 1'b1, 1'b1, 1'b1, ADDR, DATA);
    tick();
    check("wbto.fault", {29'd0, state_o}, 32'd7);
    check_bus("wbto.bus_off", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    check("wbto.retry", {24'd0, retry_cnt}, 32'd3);

    // ---- readback mismatch
    repeat (BO) tick();
    tick(); tick();
    repeat (SC) tick();
    check("badrd.cfg_wr", {29'd0, state_o}, 32'd4);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    tick();
    check_bus("badrd.rd", 1'b1, 1'b1, 1'b0, ADDR, 32'h0);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0;
    tick();
    wb_ack_i = 1'b0;
    check_status("badrd.fault", 3'd7, 1'b0, 1'b0, 1'b1);
    check("badrd.retry", {24'd0, retry_cnt}, 32'd4);

    // ---- enable drop while the read strobe is high
    repeat (BO) tick();
    tick(); tick();
    repeat (SC) tick();
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    tick();
    check("endrop.stb_high", {31'd0, wb_stb_o}, 32'd1);
    enable = 1'b0;
    tick();
    check_status("endrop.idle", 3'd0, 1'b0, 1'b0, 1'b0);
    check_bus("endrop.bus_off", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    check("endrop.ack_ignored", {29'd0, state_o}, 32'd0);
    check("endrop.retry_kept", {24'd0, retry_cnt}, 32'd4);

    // ---- forced faults until retry_cnt saturates
    enable = 1'b1; blk_lock = 1'b0;
    exp_retry = 4;
    for (int i = 0; i < 300; i++) begin
      wait_fault(LT + BO + 8);
      exp_retry = (exp_retry >= 255) ? 255 : exp_retry + 1;
      check("sat.retry", {24'd0, retry_cnt}, exp_retry[31:0]);
      repeat (BO) tick();
    end
    check("sat.final", {24'd0, retry_cnt}, 32'h0000_00FF);

    // ---- asynchronous reset in the middle of the config write
    blk_lock = 1'b1;
    tick(); tick();
    repeat (SC) tick();
    check("areset.cfg_wr", {29'd0, state_o}, 32'd4);
    check("areset.stb_before", {31'd0, wb_stb_o}, 32'd1);
    #2 async_reset_n = 1'b0;
    #1;
    check_status("areset.now", 3'd0, 1'b0, 1'b0, 1'b0);
    check_bus("areset.now", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    check("areset.retry", {24'd0, retry_cnt}, 32'd0);
    tick();
    async_reset_n = 1'b1;
    tick();
    check("areset.restart", {29'd0, state_o}, 32'd1);
    check_bus("areset.no_resume", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/link_bringup_ctrl.md
LINK_BRINGUP_CTRL -- requirements
Module: link_bringup_ctrl

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 16'd50000, meaning max cycles in WAIT_LOCK before fault.
REQ-002 SHALL have parameter STABLE_CYCLES, default 16'd1024, meaning consecutive good-lock cycles required before MAC configuration.
REQ-003 SHALL have parameter WB_TIMEOUT, default 16'd64, meaning max cycles waiting for wb_ack_i per transfer.
REQ-004 SHALL have parameter BACKOFF, default 16'd4096, meaning cycles spent in FAULT before retry.
REQ-005 SHALL have parameters CFG_ADDR (8'h00) and CFG_DATA (32'h0000_0001), meaning MAC config register address and value written then read back.
REQ-006 SHALL have ports: clk_156 in 1 (sole clock); async_reset_n in 1 (asynchronous, active-low reset).
REQ-007 SHALL have ports: enable in 1 (start/keep link); reset_tx_done in 1; reset_rx_done in 1 (transceiver resets complete).
REQ-008 SHALL have ports: blk_lock in 1; hi_ber in 1; rxlf in 1 (PCS status, already synchronous to clk_156).
REQ-009 SHALL have ports: wb_adr_o out 8; wb_dat_o out 32; wb_we_o out 1; wb_cyc_o out 1; wb_stb_o out 1; wb_ack_i in 1; wb_dat_i in 32 (Wishbone master to MAC).
REQ-010 SHALL have ports: mac_reset_n out 1; clear_ber_cnt out 1; clear_errblk out 1; link_up out 1; fault out 1; retry_cnt out 8; state_o out 3.

Function
REQ-011 SHALL implement states IDLE=0, WAIT_RST=1, WAIT_LOCK=2, STABLE=3, CFG_WR=4, CFG_RD=5, LINK_UP=6, FAULT=7, encoded on state_o.
REQ-012 SHALL use one 16-bit cycle counter, cleared on every state change, incrementing each cycle otherwise.
REQ-013 SHALL, in any state other than IDLE, go to IDLE next cycle when enable=0; this has priority over all other transitions.
REQ-014 IDLE: SHALL go to WAIT_RST when enable=1.
REQ-015 WAIT_RST: SHALL go to WAIT_LOCK when reset_tx_done=1 and reset_rx_done=1 in the same cycle.
REQ-016 WAIT_LOCK: SHALL go to STABLE when blk_lock=1 and hi_ber=0; else to FAULT when counter = LOCK_TIMEOUT-1; good-lock wins if both hold.
REQ-017 STABLE: SHALL return to WAIT_LOCK when blk_lock=0 or hi_ber=1; else go to CFG_WR when counter = STABLE_CYCLES-1.
REQ-018 SHALL pulse clear_ber_cnt and clear_errblk high for exactly one cycle, the first cycle in CFG_WR.
REQ-019 mac_reset_n SHALL be 1 only in CFG_WR, CFG_RD, LINK_UP (registered, changes with state).
REQ-020 CFG_WR: SHALL drive cyc=stb=we=1, adr=CFG_ADDR, dat=CFG_DATA, held stable until ack; on wb_ack_i=1 go to CFG_RD, with cyc/stb low for at least the next cycle.
REQ-021 CFG_RD: SHALL drive cyc=stb=1, we=0, adr=CFG_ADDR; on ack go to LINK_UP if wb_dat_i = CFG_DATA, else FAULT.
REQ-022 CFG_WR/CFG_RD: SHALL go to FAULT when counter = WB_TIMEOUT-1 without ack; ack in that same cycle wins.
REQ-023 Outside CFG_WR/CFG_RD, cyc/stb/we SHALL be 0 and adr/dat 0; leaving a Wishbone state for any reason (enable drop, timeout) SHALL deassert cyc/stb the next cycle.
REQ-024 SHALL ignore wb_ack_i outside CFG_WR/CFG_RD.
REQ-025 LINK_UP: link_up=1; SHALL go to FAULT when blk_lock=0, hi_ber=1 or rxlf=1.
REQ-026 FAULT: fault=1; SHALL go to WAIT_RST when counter = BACKOFF-1.
REQ-027 retry_cnt SHALL increment by 1 on each entry into FAULT, saturating at 8'hFF; cleared only by reset.
REQ-028 Counter compare SHALL be exact equality on 16 bits; parameter value 0 behaves as 65536.

Reset
REQ-029 While async_reset_n=0: state=IDLE, counter=0, retry_cnt=0, mac_reset_n=0, link_up=0, fault=0, clear pulses 0, all Wishbone outputs 0; asserted asynchronously, released synchronously to clk_156.
REQ-030 Reset mid-transfer SHALL drop cyc/stb immediately; no transfer resumes after release.

Verification
REQ-031 Clean bring-up: enable=1, resets done, blk_lock=1 -> STABLE after 1 cycle, CFG_WR after 1024, one clear pulse, ack after 3 cycles, readback 1 -> link_up=1, mac_reset_n=1, retry_cnt=0.
REQ-032 Lock never achieved: blk_lock=0 -> FAULT at counter 49999, retry_cnt=1, mac_reset_n=0, WAIT_RST after 4096 cycles.
REQ-033 Lock glitch: blk_lock drops at STABLE count 500 -> WAIT_LOCK, counter restarts; full 1024 required again.
REQ-034 Wishbone: no ack -> FAULT after 64 cycles, cyc=0 next cycle; readback 32'h0 -> FAULT, retry_cnt increments.
REQ-035 LINK_UP then rxlf=1 -> FAULT next cycle, link_up=0, mac_reset_n=0; 300 forced faults -> retry_cnt=8'hFF.
REQ-036 enable=0 during CFG_RD with stb high -> IDLE and stb=0 next cycle; async reset mid-CFG_WR -> all outputs 0 immediately.
